cpu_sequencer: RTL and testbench

- Multi-cycle controller that drives the single-cycle execute datapath: it fetches an instruction, latches it, steps the datapath through its phases and commits the results.
- It owns the PC and instruction registers and gates register-file and data-memory writes so each happens exactly once per instruction.
- It adds a memory phase for loads and stores, because the data memory has a one-cycle synchronous read.
- Sits between the instruction memory, the register file and the execute datapath, at the top of the computer.

---
 rtl/cpu_sequencer_pkg.sv | 38 +++
 rtl/cpu_sequencer_seq_fsm.sv | 97 +++++++++
 rtl/cpu_sequencer.sv | 110 +++++++++++
 tb/tb_cpu_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs
//   Shared definitions for the multi-cycle CPU sequencer:
//   - state_t : FSM state encoding (also exported on the debug state port)
//   - OP_*    : opcodes the sequencer decodes itself (memory ops and halt)
//   - is_mem_op() : true for opcodes that need the extra MEM phase
// -----------------------------------------------------------------------------
package cpu_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ILL    = 3'd7   // unreachable in normal operation; recovers to IDLE
  } state_t;

  localparam logic [5:0] OP_LW   = 6'd16;
  localparam logic [5:0] OP_LH   = 6'd18;
  localparam logic [5:0] OP_LB   = 6'd20;
  localparam logic [5:0] OP_SW   = 6'd24;
  localparam logic [5:0] OP_SH   = 6'd26;
  localparam logic [5:0] OP_SB   = 6'd28;
  localparam logic [5:0] OP_HALT = 6'd63;

  // Loads and stores need one extra cycle because the data memory read is
  // synchronous (data appears the cycle after the address).
  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_seq_fsm.sv
// -----------------------------------------------------------------------------
// seq_fsm
//   State register, next-state logic and strobe decode for the sequencer.
//   All strobes are pure functions of the current state (and the opcode for
//   the WB branch), so an asynchronous reset clears them without a clock edge.
//
// Ports
//   clk      in   system clock
//   rstd     in   asynchronous active-low reset
//   run      in   1 = keep executing; sampled in IDLE and at the end of WB
//   op       in   opcode of the latched instruction (ins[31:26])
//   state    out  current state
//   ir_load  out  load the instruction register (DECODE)
//   wb_slot  out  writeback / retire cycle (WB)
//   pc_load  out  take nextpc into the PC (WB of a non-halt instruction)
//   dm_we_en out  data-memory write enable window (MEM)
//   halted   out  1 while in HALT
// -----------------------------------------------------------------------------
module seq_fsm
  import cpu_defs::*;
#(
  parameter logic [5:0] HALT_OP = OP_HALT
) (
  input  logic       clk,
  input  logic       rstd,
  input  logic       run,
  input  logic [5:0] op,
  output state_t     state,
  output logic       ir_load,
  output logic       wb_slot,
  output logic       pc_load,
  output logic       dm_we_en,
  output logic       halted
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_load  = 1'b0;
    wb_slot  = 1'b0;
    pc_load  = 1'b0;
    dm_we_en = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // imem_addr is already driven from pc; memory answers next cycle.
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ir_load = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = is_mem_op(op) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        // One-cycle window: a store commits on the edge leaving MEM.
        dm_we_en = 1'b1;
        state_d  = ST_WB;
      end
      ST_WB: begin
        wb_slot = 1'b1;
        if (op == HALT_OP) begin
          // PC is frozen at the halt instruction's own address.
          state_d = ST_HALT;
        end else begin
          pc_load = 1'b1;
          // run is only honoured here, so a drop never cuts an instruction.
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle controller for the single-cycle execute datapath. Owns the PC,
//   the instruction register and the retired-instruction counter, and gates
//   register-file / data-memory writes so each happens once per instruction.
//   Sequence: FETCH, DECODE, EXEC, [MEM for loads/stores], WB.
//
// Ports
//   clk        in   system clock, rising edge
//   rstd       in   asynchronous active-low reset
//   run        in   1 = execute, 0 = pause at the next instruction boundary
//   imem_addr  out  instruction word address = pc[IMEM_AW-1:0]
//   imem_data  in   instruction read data, valid one cycle after imem_addr
//   ins        out  latched instruction
//   pc         out  current PC
//   nextpc     in   next PC computed by the datapath
//   wra        in   destination register from the datapath
//   result     in   writeback value from the datapath
//   rf_we      out  register-file write strobe (WB only, never for r0)
//   rf_wa      out  register-file write address
//   rf_wd      out  register-file write data
//   dm_we_en   out  global data-memory write enable (MEM only)
//   state      out  FSM state for debug
//   halted     out  1 while halted
//   instret    out  retired instruction count (wraps at 2^32)
// -----------------------------------------------------------------------------
module cpu_sequencer
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [5:0]  HALT_OP  = OP_HALT,
  parameter int          IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rstd,
  input  logic               run,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        ins,
  output logic [31:0]        pc,
  input  logic [31:0]        nextpc,
  input  logic [4:0]         wra,
  input  logic [31:0]        result,
  output logic               rf_we,
  output logic [4:0]         rf_wa,
  output logic [31:0]        rf_wd,
  output logic               dm_we_en,
  output logic [2:0]         state,
  output logic               halted,
  output logic [31:0]        instret
);

  state_t fsm_state;
  logic   ir_load;
  logic   wb_slot;
  logic   pc_load;

  seq_fsm #(
    .HALT_OP (HALT_OP)
  ) u_fsm (
    .clk      (clk),
    .rstd     (rstd),
    .run      (run),
    .op       (ins[31:26]),
    .state    (fsm_state),
    .ir_load  (ir_load),
    .wb_slot  (wb_slot),
    .pc_load  (pc_load),
    .dm_we_en (dm_we_en),
    .halted   (halted)
  );

  assign state = fsm_state;

  // Program counter: only moves at the end of WB.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      pc <= RESET_PC;
    end else if (pc_load) begin
      pc <= nextpc;
    end
  end

  // Instruction register: captured at the end of DECODE, when the synchronous
  // instruction memory has returned the word addressed during FETCH.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      ins <= 32'd0;
    end else if (ir_load) begin
      ins <= imem_data;
    end
  end

  // Retired count includes the halt instruction itself.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      instret <= 32'd0;
    end else if (wb_slot) begin
      instret <= instret + 32'd1;
    end
  end

  assign imem_addr = pc[IMEM_AW-1:0];

  // r0 is hard-wired to zero, so its writes are suppressed here.
  assign rf_we = wb_slot && (wra != 5'd0);
  assign rf_wa = wra;
  assign rf_wd = result;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstd;
  logic          run;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [31:0]   ins;
  logic [31:0]   pc;
  logic [31:0]   nextpc;
  logic [4:0]    wra;
  logic [31:0]   result;
  logic          rf_we;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd;
  logic          dm_we_en;
  logic [2:0]    state;
  logic          halted;
  logic [31:0]   instret;

  logic [31:0]   imem [0:255];

  always #5 clk = ~clk;

  cpu_sequencer #(
    .RESET_PC (32'd0),
    .HALT_OP  (6'd63),
    .IMEM_AW  (AW)
  ) dut (
    .clk       (clk),
    .rstd      (rstd),
    .run       (run),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .ins       (ins),
    .pc        (pc),
    .nextpc    (nextpc),
    .wra       (wra),
    .result    (result),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .dm_we_en  (dm_we_en),
    .state     (state),
    .halted    (halted),
    .instret   (instret)
  );

  // Synchronous instruction memory: one cycle read latency.
  always @(posedge clk) imem_data <= imem[imem_addr];

  // Stand-in datapath: op 2 is an absolute jump to the sign-extended imm,
  // everything else falls through to pc+1.
  function automatic logic [31:0] dp_nextpc(input logic [31:0] i, input logic [31:0] p);
    if (i[31:26] == 6'd2) return {{16{i[15]}}, i[15:0]};
    return p + 32'd1;
  endfunction

  function automatic logic [4:0] dp_wra(input logic [31:0] i);
    return i[20:16];
  endfunction

  function automatic logic [31:0] dp_result(input logic [31:0] i, input logic [31:0] p);
    return {16'd0, i[15:0]} ^ {p[15:0], 16'd0};
  endfunction

  assign nextpc = dp_nextpc(ins, pc);
  assign wra    = dp_wra(ins);
  assign result = dp_result(ins, pc);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        rfwe;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mem;
    logic        halt;
    logic [31:0] instret;
    int          lat;
  } rec_t;

  rec_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          retired = 0;
  int          base = 0;
  logic [31:0] exp_instret = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: walks the program from start_pc, one record per
  // retired instruction, stopping at a halt or after n instructions.
  task automatic model_walk(input logic [31:0] start_pc, input int n,
                            output logic [31:0] end_pc, output int cnt);
    logic [31:0] p;
    logic [31:0] i;
    logic [5:0]  op;
    rec_t        r;
    p   = start_pc;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      i         = imem[p[7:0]];
      op        = i[31:26];
      r.pc      = p;
      r.ins     = i;
      r.wa      = dp_wra(i);
      r.wd      = dp_result(i, p);
      r.rfwe    = (r.wa != 5'd0);
      r.mem     = op inside {6'd16, 6'd18, 6'd20, 6'd24, 6'd26, 6'd28};
      r.halt    = (op == 6'd63);
      r.instret = exp_instret;
      r.lat     = r.mem ? 5 : 4;
      sb.push_back(r);
      exp_instret = exp_instret + 32'd1;
      cnt++;
      if (r.halt) break;
      p = dp_nextpc(i, p);
    end
    end_pc = p;
  endtask

  // Monitor: samples on the falling edge, pops one record per WB.
  int          mon_cyc = 0;
  int          dm_cnt = 0;
  logic [2:0]  prev_state = 3'd0;
  logic        prev_run = 1'b0;
  logic        prev_halt = 1'b0;
  rec_t        mr;

  always @(negedge clk) begin
    if (!rstd) begin
      mon_cyc    = 0;
      dm_cnt     = 0;
      prev_state = 3'd0;
      prev_run   = 1'b0;
      prev_halt  = 1'b0;
    end else begin
      check("dm_we_en_only_in_mem", 32'(dm_we_en), 32'(state == 3'd4));
      check("halted_only_in_halt", 32'(halted), 32'(state == 3'd6));
      check("imem_addr_eq_pc", 32'(imem_addr), {24'd0, pc[7:0]});
      if (state != 3'd5) check("rf_we_outside_wb", 32'(rf_we), 32'd0);
      if (state == 3'd0 && prev_state != 3'd0) check("pause_only_after_wb", 32'(prev_state), 32'd5);
      if (prev_state == 3'd5 && prev_run && !prev_halt) check("back_to_back_fetch", 32'(state), 32'd1);
      if (state == 3'd1) begin
        mon_cyc = 1;
        dm_cnt  = 0;
      end else if (state >= 3'd2 && state <= 3'd5) begin
        mon_cyc++;
      end
      if (dm_we_en) dm_cnt++;
      if (state == 3'd5) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          mr = sb.pop_front();
          check("wb_pc", pc, mr.pc);
          check("wb_ins", ins, mr.ins);
          check("wb_rf_we", 32'(rf_we), 32'(mr.rfwe));
          if (mr.rfwe) begin
            check("wb_rf_wa", 32'(rf_wa), 32'(mr.wa));
            check("wb_rf_wd", rf_wd, mr.wd);
          end
          check("wb_instret", instret, mr.instret);
          check("dm_pulses", 32'(dm_cnt), mr.mem ? 32'd1 : 32'd0);
          check("latency", 32'(mon_cyc), 32'(mr.lat));
          prev_halt = mr.halt;
        end
        retired++;
      end
      prev_state = state;
      prev_run   = run;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstd = 1'b0;
    run  = 1'b0;
    step();
    step();
    sb.delete();
    exp_instret = 32'd0;
    rstd = 1'b1;
    base = retired;
  endtask

  task automatic clear_imem();
    for (int a = 0; a < 256; a++) imem[a] = 32'd0;
  endtask

  task automatic load_prog1();
    clear_imem();
    imem[0]   = {6'd1,  5'd0, 5'd1, 16'd5};
    imem[1]   = {6'd1,  5'd1, 5'd2, 16'h0007};
    imem[2]   = {6'd1,  5'd2, 5'd3, 16'h1234};
    imem[3]   = {6'd24, 5'd1, 5'd0, 16'h0004};
    imem[4]   = {6'd2,  5'd0, 5'd0, 16'h0010};
    imem[16]  = {6'd16, 5'd0, 5'd4, 16'h0008};
    imem[17]  = {6'd2,  5'd0, 5'd0, 16'hFFFF};
    imem[255] = {6'd1,  5'd0, 5'd7, 16'h0ABC};
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0]  op;
    logic [15:0] imm;
    case ($urandom_range(0, 9))
      0: op = 6'd1;  1: op = 6'd2;  2: op = 6'd5;  3: op = 6'd16; 4: op = 6'd18;
      5: op = 6'd20; 6: op = 6'd24; 7: op = 6'd26; 8: op = 6'd28; default: op = 6'd0;
    endcase
    imm = 16'($urandom);
    if (op == 6'd2) imm = ($urandom_range(0, 7) == 0) ? 16'hFFFF : {8'd0, 8'($urandom)};
    return {op, 5'($urandom), 5'($urandom), imm};
  endfunction

  initial begin
    logic [31:0] end_pc;
    int          cnt;
    int          guard;
    bit          ok;

    rstd = 1'b0;
    run  = 1'b0;
    clear_imem();
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_ins", ins, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_dm_we_en", 32'(dm_we_en), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    rstd = 1'b1;
    base = retired;
    for (int k = 0; k < 3; k++) step();
    check("idle_without_run", 32'(state), 32'd0);

    // Directed program: ALU, store, branch, load, jump to 0xFFFFFFFF, wrap.
    load_prog1();
    model_walk(32'd0, 9, end_pc, cnt);
    run = 1'b1;
    guard = 0;
    while (!((retired - base) == 8 && state == 3'd3) && guard < 200) begin
      step();
      guard++;
    end
    check("prog1_reach_last_exec", 32'(guard < 200), 32'd1);
    run = 1'b0;
    guard = 0;
    while (!((retired - base) == 9 && state == 3'd0) && guard < 50) begin
      step();
      guard++;
    end
    check("prog1_pause_idle", 32'(guard < 50), 32'd1);
    check("prog1_end_pc", pc, end_pc);
    check("prog1_instret", instret, exp_instret);
    check("prog1_sb_empty", 32'(sb.size()), 32'd0);

    // Resume from the paused PC.
    model_walk(end_pc, 1, end_pc, cnt);
    run = 1'b1;
    step();
    check("resume_fetch_state", 32'(state), 32'd1);
    check("resume_imem_addr", 32'(imem_addr), 32'd1);
    run = 1'b0;
    guard = 0;
    while (!((retired - base) == 10 && state == 3'd0) && guard < 50) begin
      step();
      guard++;
    end
    check("resume_complete", 32'(guard < 50), 32'd1);
    check("resume_pc", pc, end_pc);

    // Halt program.
    do_reset();
    clear_imem();
    imem[0] = {6'd1,  5'd0, 5'd1, 16'h0011};
    imem[1] = {6'd1,  5'd0, 5'd2, 16'h0022};
    imem[2] = {6'd63, 5'd0, 5'd0, 16'h0000};
    model_walk(32'd0, 10, end_pc, cnt);
    run = 1'b1;
    guard = 0;
    while (!halted && guard < 50) begin
      step();
      guard++;
    end
    check("halt_reached", 32'(halted), 32'd1);
    check("halt_pc", pc, 32'd2);
    check("halt_instret", instret, 32'd3);
    check("halt_state", 32'(state), 32'd6);
    check("halt_sb_empty", 32'(sb.size()), 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (state != 3'd6 || pc != 32'd2 || !halted || instret != 32'd3) ok = 1'b0;
    end
    check("halt_hold_100", 32'(ok), 32'd1);

    // Asynchronous reset while a store sits in MEM.
    do_reset();
    check("reset_leaves_halt", 32'(state), 32'd0);
    load_prog1();
    model_walk(32'd0, 4, end_pc, cnt);
    run = 1'b1;
    guard = 0;
    while (!((retired - base) == 3 && state == 3'd4) && guard < 100) begin
      step();
      guard++;
    end
    check("store_mem_reached", 32'(dm_we_en), 32'd1);
    rstd = 1'b0;
    #1;
    check("async_dm_we_en", 32'(dm_we_en), 32'd0);
    check("async_state", 32'(state), 32'd0);
    check("async_pc", pc, 32'd0);
    check("async_instret", instret, 32'd0);
    check("async_ins", ins, 32'd0);
    sb.delete();
    exp_instret = 32'd0;
    run = 1'b0;
    step();
    rstd = 1'b1;
    base = retired;

    // Random program with run toggling at random times.
    clear_imem();
    for (int a = 0; a < 256; a++) imem[a] = rand_ins();
    model_walk(32'd0, 40, end_pc, cnt);
    guard = 0;
    while (guard < 3000) begin
      if ((retired - base) == 39 && state != 3'd0 && state != 3'd5) break;
      if ((retired - base) == 39 && state == 3'd0) run = 1'b1;
      else run = ($urandom_range(0, 3) != 0);
      step();
      guard++;
    end
    check("rand_reach_last", 32'(guard < 3000), 32'd1);
    run = 1'b0;
    guard = 0;
    while (!((retired - base) == 40 && state == 3'd0) && guard < 50) begin
      step();
      guard++;
    end
    check("rand_pause_idle", 32'(guard < 50), 32'd1);
    check("rand_end_pc", pc, end_pc);
    check("rand_instret", instret, 32'd40);
    check("rand_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
